// File: rtl/raster_pkg.sv
// Shared types and default geometry for the raster generator.
// HBLANK/VBLANK states exist only when RASTER_BLANKING_EN is defined.
package raster_pkg;

   localparam int H_ACTIVE_DEF = 12;
   localparam int V_ACTIVE_DEF = 8;
   localparam int H_BLANK_DEF  = 2;
   localparam int V_BLANK_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1
`ifdef RASTER_BLANKING_EN
      ,
      HBLANK = 2'd2,
      VBLANK = 2'd3
`endif
   } state_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Wrap counter: counts 0..last on enable, then returns to 0.
// tc flags the terminal value; clear and reset both force zero.
module raster_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] last,
   output logic [W-1:0] count,
   output logic         tc
);

   assign tc = (count == last);

   always_ff @(posedge clk) begin
      if (reset || clear)
         count <= '0;
      else if (enable)
         count <= tc ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/raster_gen.sv
// Raster coordinate generator with valid/ready handshake and frame flags.
// Optional line/frame blanking is compiled in with RASTER_BLANKING_EN.
module raster_gen
   import raster_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int X_W      = 4,
   parameter int Y_W      = 4,
   parameter int H_BLANK  = H_BLANK_DEF,
   parameter int V_BLANK  = V_BLANK_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           stop,
   input  logic           continuous,
   input  logic           ready,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           valid,
   output logic           sof,
   output logic           eol,
   output logic           eof,
   output logic           busy
);

   state_t state, state_nx;
   logic   xfer, x_tc, y_tc;

   assign xfer = valid && ready;

   // x and y only move on a transfer and wrap through their terminal compare.
   raster_counter #(.W(X_W)) u_x (
      .clk(clk), .reset(reset), .clear(stop), .enable(xfer),
      .last(X_W'(H_ACTIVE - 1)), .count(x), .tc(x_tc)
   );

   raster_counter #(.W(Y_W)) u_y (
      .clk(clk), .reset(reset), .clear(stop), .enable(xfer && x_tc),
      .last(Y_W'(V_ACTIVE - 1)), .count(y), .tc(y_tc)
   );

`ifdef RASTER_BLANKING_EN
   localparam int B_W = cnt_w((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);

   logic           in_blank, b_tc;
   logic [B_W-1:0] b_cnt, b_last;

   assign in_blank = (state == HBLANK) || (state == VBLANK);
   assign b_last   = (state == HBLANK) ? B_W'(H_BLANK - 1) : B_W'(V_BLANK - 1);

   // Held at zero outside blanking so each blank period starts fresh.
   raster_counter #(.W(B_W)) u_blank (
      .clk(clk), .reset(reset), .clear(stop || !in_blank), .enable(in_blank),
      .last(b_last), .count(b_cnt), .tc(b_tc)
   );
`endif

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:
            if (start) state_nx = ACTIVE;
         ACTIVE:
            if (xfer && x_tc) begin
`ifdef RASTER_BLANKING_EN
               if (!y_tc)
                  state_nx = HBLANK;
               else
                  state_nx = continuous ? VBLANK : IDLE;
`else
               if (y_tc)
                  state_nx = continuous ? ACTIVE : IDLE;
`endif
            end
`ifdef RASTER_BLANKING_EN
         HBLANK, VBLANK:
            if (b_tc) state_nx = ACTIVE;
`endif
         default:
            state_nx = IDLE;
      endcase
      if (stop) state_nx = IDLE;
   end

   always_comb begin
      valid = (state == ACTIVE);
      busy  = (state != IDLE);
      sof   = valid && (x == '0) && (y == '0);
      eol   = valid && x_tc;
      eof   = valid && x_tc && y_tc;
   end

endmodule

// File: tb/tb_raster_gen.sv
// Self-checking bench for raster_gen: vector table, directed corner cases
// and a randomized run compared against a frame-walking reference model.
module tb_raster_gen;

   localparam int H  = 12;
   localparam int V  = 8;
   localparam int HB = 2;
   localparam int VB = 4;
`ifdef RASTER_BLANKING_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, start, stop, continuous, ready;
   logic [3:0] x, y;
   logic       valid, sof, eol, eof, busy;

   int checks   = 0;
   int failures = 0;

   raster_gen dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .continuous(continuous), .ready(ready), .x(x), .y(y),
      .valid(valid), .sof(sof), .eol(eol), .eof(eof), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 idle, 1 scanning, 2 blanking with blank_left cycles to go.
   int m_mode, mx, my, m_left;

   function automatic logic [12:0] model_vec();
      logic v;
      v = (m_mode == 1);
      return {m_mode != 0, v, v && mx == 0 && my == 0, v && mx == H-1,
              v && mx == H-1 && my == V-1, 4'(mx), 4'(my)};
   endfunction

   function automatic logic [12:0] dut_vec();
      return {busy, valid, sof, eol, eof, x, y};
   endfunction

   function automatic logic [12:0] ov(input bit b, input bit v, input bit s,
                                      input bit l, input bit f, input int px, input int py);
      return {b, v, s, l, f, 4'(px), 4'(py)};
   endfunction

   task automatic model_step();
      if (reset) begin
         m_mode = 0; mx = 0; my = 0; m_left = 0;
      end else if (stop) begin
         m_mode = 0; mx = 0; my = 0;
      end else begin
         case (m_mode)
            0: if (start) m_mode = 1;
            1: if (ready) begin
               if (mx < H-1) mx++;
               else begin
                  mx = 0;
                  if (my < V-1) begin
                     my++;
                     if (BLANK) begin m_mode = 2; m_left = HB; end
                  end else begin
                     my = 0;
                     if (!continuous) m_mode = 0;
                     else if (BLANK) begin m_mode = 2; m_left = VB; end
                  end
               end
            end
            default: begin
               m_left--;
               if (m_left == 0) m_mode = 1;
            end
         endcase
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("model", dut_vec(), model_vec());
   endtask

   task automatic run_to(input int tx, input int ty);
      int n = 0;
      while (!(valid && x == 4'(tx) && y == 4'(ty)) && n < 400) begin
         tick();
         n++;
      end
      check("run_to", {valid, x, y}, {1'b1, 4'(tx), 4'(ty)});
   endtask

   typedef struct {
      logic        rst, st, sp, rdy;
      logic [12:0] exp;
   } vec_t;

   vec_t tbl [11];
   int   seen, cyc, gap;

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; ready = 1'b0;

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, ov(0,0,0,0,0,0,0)};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, ov(0,0,0,0,0,0,0)};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, ov(1,1,1,0,0,0,0)};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, ov(1,1,1,0,0,0,0)};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, ov(1,1,0,0,0,1,0)};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, ov(1,1,0,0,0,2,0)};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, ov(0,0,0,0,0,0,0)};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, ov(1,1,1,0,0,0,0)};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, ov(0,0,0,0,0,0,0)};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, ov(1,1,1,0,0,0,0)};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, ov(0,0,0,0,0,0,0)};

      for (int i = 0; i < 11; i++) begin
         reset = tbl[i].rst; start = tbl[i].st; stop = tbl[i].sp; ready = tbl[i].rdy;
         tick();
         check("table", dut_vec(), tbl[i].exp);
      end

      // Full single frame with ready held high, then back to idle.
      reset = 1'b1; stop = 1'b0; start = 1'b0; tick();
      reset = 1'b0; start = 1'b1; continuous = 1'b0; ready = 1'b1;
      seen = 0; cyc = 0;
      while (seen < H*V && cyc < 400) begin
         tick();
         cyc++;
         if (valid) begin
            check("raster", dut_vec(), ov(1, 1, seen == 0, (seen % H) == H-1,
                                          seen == H*V-1, seen % H, seen / H));
            seen++;
         end
      end
      check("raster_count", seen, H*V);
`ifndef RASTER_BLANKING_EN
      check("raster_cycles", cyc, H*V);
`endif
      tick();
      check("frame_end_idle", dut_vec(), ov(0,0,0,0,0,0,0));
      start = 1'b0;

      // Back-pressure at (5,2).
      reset = 1'b1; tick();
      reset = 1'b0; start = 1'b1; ready = 1'b1; tick();
      start = 1'b0;
      run_to(5, 2);
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold", dut_vec(), ov(1,1,0,0,0,5,2));
      end
      ready = 1'b1; tick();
      check("resume", dut_vec(), ov(1,1,0,0,0,6,2));

      // Stop beats start mid-frame.
      run_to(7, 4);
      stop = 1'b1; start = 1'b1; tick();
      check("stop", dut_vec(), ov(0,0,0,0,0,0,0));
      stop = 1'b0; start = 1'b0; tick();

`ifdef RASTER_BLANKING_EN
      // Blank gaps in continuous mode across a frame boundary.
      reset = 1'b1; tick();
      reset = 1'b0; start = 1'b1; continuous = 1'b1; ready = 1'b1; tick();
      start = 1'b0;
      for (int l = 0; l < V + 1; l++) begin
         run_to(H-1, l % V);
         gap = 0;
         tick();
         while (!valid && gap < 20) begin gap++; tick(); end
         check("gap", gap, (l % V == V-1) ? VB : HB);
         check("after_gap", {valid, sof, x, y},
               {1'b1, (l % V == V-1), 4'd0, 4'((l + 1) % V)});
      end

      // Reset in the middle of a line blank, then immediate restart.
      continuous = 1'b0;
      run_to(H-1, 1);
      tick();
      reset = 1'b1; tick();
      check("rst_hblank", dut_vec(), ov(0,0,0,0,0,0,0));
      reset = 1'b0; start = 1'b1; tick();
      check("start_after_rst", dut_vec(), ov(1,1,1,0,0,0,0));
      start = 1'b0;
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom_range(0, 199) == 0);
         stop       = ($urandom_range(0, 99) == 0);
         start      = ($urandom_range(0, 3) == 0);
         continuous = $urandom_range(0, 1) != 0;
         ready      = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
